// File: rtl/spmv_row_scheduler.sv
// spmv_row_scheduler: walks CSR row_ptr/col_idx in SRAM1 and streams nonzeros and row ends to the MAC core.
module spmv_row_scheduler #(
  parameter int N_ROWS  = 16,
  parameter int PTR_W   = 8,
  parameter int ADDR_W  = 10,
  parameter int RP_BASE = 0,
  parameter int CI_BASE = 64,
  localparam int RW = N_ROWS > 1 ? $clog2(N_ROWS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [15:0]       i_rd_data,
  output logic              o_elem_valid,
  input  logic              i_elem_ready,
  output logic [PTR_W-1:0]  o_elem_idx,
  output logic [15:0]       o_elem_col,
  output logic              o_elem_last,
  output logic              o_row_valid,
  input  logic              i_row_ready,
  output logic [RW-1:0]     o_row_idx,
  output logic              o_row_empty
);
  localparam logic [3:0] IDLE = 4'd0, RD_RP0 = 4'd1, WT_RP0 = 4'd2, RD_RP = 4'd3, WT_RP = 4'd4,
                         RD_CI = 4'd5, WT_CI = 4'd6, ISSUE = 4'd7, ROW_END = 4'd8, DONE = 4'd9;
  logic [3:0] st;
  logic [RW-1:0] r;
  logic [PTR_W-1:0] ptr, end_ptr, dp;
  logic [15:0] col;
  logic empty, bad, last;
  assign dp = i_rd_data[PTR_W-1:0];
  // pointer words with any bit above PTR_W set cannot be represented
  assign bad = (i_rd_data >> PTR_W) != 16'd0;
  assign last = PTR_W'(ptr + 1'b1) == end_ptr;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= IDLE;
      r <= '0;
      ptr <= '0;
      end_ptr <= '0;
      col <= '0;
      empty <= 1'b0;
      o_err <= 1'b0;
    end else begin
      case (st)
        IDLE: if (i_start) begin
          st <= RD_RP0;
          r <= '0;
          o_err <= 1'b0;
        end
        RD_RP0: st <= WT_RP0;
        WT_RP0: if (bad) begin
          o_err <= 1'b1;
          st <= DONE;
        end else begin
          ptr <= dp;
          st <= RD_RP;
        end
        RD_RP: st <= WT_RP;
        WT_RP: begin
          end_ptr <= dp;
          empty <= dp == ptr;
          if (bad || dp < ptr) begin
            o_err <= 1'b1;
            st <= DONE;
          end else st <= dp == ptr ? ROW_END : RD_CI;
        end
        RD_CI: st <= WT_CI;
        WT_CI: begin
          col <= i_rd_data;
          st <= ISSUE;
        end
        ISSUE: if (i_elem_ready) begin
          ptr <= ptr + 1'b1;
          st <= last ? ROW_END : RD_CI;
        end
        // ptr already equals row_ptr[r+1], the next row's start
        ROW_END: if (i_row_ready) begin
          if (r == RW'(N_ROWS - 1)) st <= DONE;
          else begin
            r <= r + 1'b1;
            st <= RD_RP;
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
  assign o_busy = st != IDLE;
  assign o_done = st == DONE;
  assign o_rd_en = st == RD_RP0 || st == RD_RP || st == RD_CI;
  assign o_rd_addr = st == RD_RP0 ? ADDR_W'(RP_BASE) :
                     st == RD_RP  ? ADDR_W'(RP_BASE) + ADDR_W'(r) + ADDR_W'(1) :
                     st == RD_CI  ? ADDR_W'(CI_BASE) + ADDR_W'(ptr) : '0;
  assign o_elem_valid = st == ISSUE;
  assign o_elem_idx = o_elem_valid ? ptr : '0;
  assign o_elem_col = o_elem_valid ? col : '0;
  assign o_elem_last = o_elem_valid && last;
  assign o_row_valid = st == ROW_END;
  assign o_row_idx = o_row_valid ? r : '0;
  assign o_row_empty = o_row_valid && empty;
endmodule

// File: tb/tb_spmv_row_scheduler.sv
// tb_spmv_row_scheduler: directed and randomized CSR walks checked against an event-list model of the scheduler.
module tb_spmv_row_scheduler;
  localparam int NR = 4, PW = 8, AW = 10, RPB = 0, CIB = 64;
  logic clk = 0, rst = 1, start = 0, elem_ready = 0, row_ready = 0;
  logic [15:0] rd_data = 0;
  logic busy, done, err, rd_en, elem_valid, elem_last, row_valid, row_empty;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] elem_idx;
  logic [15:0] elem_col;
  logic [1:0] row_idx;

  spmv_row_scheduler #(.N_ROWS(NR), .PTR_W(PW), .ADDR_W(AW), .RP_BASE(RPB), .CI_BASE(CIB)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done), .o_err(err),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_elem_valid(elem_valid), .i_elem_ready(elem_ready), .o_elem_idx(elem_idx),
    .o_elem_col(elem_col), .o_elem_last(elem_last),
    .o_row_valid(row_valid), .i_row_ready(row_ready), .o_row_idx(row_idx), .o_row_empty(row_empty));

  always #5 clk = ~clk;

  logic [15:0] mem [0:1023];
  // SRAM1: data one cycle after the strobe, noise otherwise
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'($urandom);

  typedef struct {bit is_row; int a; int b; bit c; int cyc;} ev_t;
  ev_t exp_q[$];
  int rp[0:NR];
  int ci[0:63];
  int checks = 0, failures = 0;
  int cyc, exp_done;
  bit exp_err;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint all_outs();
    return {busy, done, err, rd_en, rd_addr, elem_valid, elem_idx, elem_col, elem_last,
            row_valid, row_idx, row_empty};
  endfunction

  // Expected offer sequence and, with ready always high, the cycle of each offer.
  function automatic void build(input bit timed);
    int s, e, n, t;
    exp_q.delete();
    exp_err = 0;
    s = rp[0];
    t = 3;
    exp_done = -1;
    if (s > 255) begin
      exp_err = 1;
      return;
    end
    for (int r = 0; r < NR; r++) begin
      e = rp[r + 1];
      if (e > 255 || e < s) begin
        exp_err = 1;
        exp_done = timed ? t + 2 : -1;
        return;
      end
      n = e - s;
      for (int k = 0; k < n; k++)
        exp_q.push_back('{0, s + k, ci[s + k] & 16'hffff, k == n - 1, timed ? t + 4 + 3 * k : -1});
      exp_q.push_back('{1, r, 0, n == 0, timed ? t + 3 * n + 2 : -1});
      t = t + 3 * n + 3;
      s = e;
    end
    exp_done = timed ? t : -1;
  endfunction

  task automatic run(input int mode, input bit timed);
    ev_t ev;
    int hold;
    bit pv_e, pr_e, pv_r, pr_r, fin;
    longint pay_e, pay_r;
    for (int i = 0; i <= NR; i++) mem[RPB + i] = 16'(rp[i]);
    for (int j = 0; j < 64; j++) mem[CIB + j] = 16'(ci[j]);
    build(timed);
    start = 1;
    cyc = 0;
    hold = 0;
    {pv_e, pr_e, pv_r, pr_r, fin} = '0;
    while (!fin) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (mode == 1 && !done) ? ($urandom % 4 == 0) : 1'b0;
      if (cyc == 1) begin
        chk("start_err_clear", err, 0);
        chk("start_rd", {busy, rd_en, rd_addr}, {2'b11, AW'(RPB)});
      end
      if (!(elem_valid || row_valid)) hold = 0;
      elem_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : hold >= 5;
      row_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : hold >= 5;
      chk("valid_excl", elem_valid && row_valid, 0);
      if (pv_e && !pr_e) chk("elem_stable", {elem_valid, elem_idx, elem_col, elem_last}, pay_e);
      if (pv_r && !pr_r) chk("row_stable", {row_valid, row_idx, row_empty}, pay_r);
      pv_e = elem_valid;
      pr_e = elem_ready;
      pay_e = {elem_valid, elem_idx, elem_col, elem_last};
      pv_r = row_valid;
      pr_r = row_ready;
      pay_r = {row_valid, row_idx, row_empty};
      if ((elem_valid && elem_ready) || (row_valid && row_ready)) begin
        hold = 0;
        if (exp_q.size() == 0) chk("extra_offer", 1, 0);
        else begin
          ev = exp_q.pop_front();
          chk("offer_kind", row_valid, ev.is_row);
          if (timed) chk("offer_cycle", cyc, ev.cyc);
          if (row_valid) chk("row", {row_idx, row_empty}, {2'(ev.a), ev.c});
          else chk("elem", {elem_idx, elem_col, elem_last}, {8'(ev.a), 16'(ev.b), ev.c});
        end
      end else if (elem_valid || row_valid) hold++;
      if (done) begin
        start = 0;
        chk("done_err", err, exp_err);
        chk("done_left", exp_q.size(), 0);
        if (timed) chk("done_cycle", cyc, exp_done);
        fin = 1;
      end else if (cyc > 3000) begin
        chk("timeout", 1, 0);
        fin = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("after_done", {busy, done}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 0);
    rst = 0;
    @(posedge clk);
    #1;
    // single populated row followed by empty rows, exact timing
    rp = '{0, 2, 2, 2, 2};
    ci[0] = 5;
    ci[1] = 9;
    run(0, 1);
    // empty rows around a three-element row
    rp = '{0, 0, 3, 3, 3};
    for (int j = 0; j < 64; j++) ci[j] = 100 + j;
    run(0, 1);
    run(1, 0);
    // backpressure: every offer stalls five cycles
    run(2, 0);
    // malformed: decreasing pointer
    rp = '{0, 4, 2, 2, 2};
    run(1, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("err_sticky", {err, busy}, 2'b10);
    end
    // malformed: pointer beyond PTR_W
    rp = '{0, 1, 300, 300, 300};
    run(0, 0);
    // reset while an element is offered
    rp = '{0, 2, 2, 2, 2};
    for (int i = 0; i <= NR; i++) mem[RPB + i] = 16'(rp[i]);
    elem_ready = 0;
    row_ready = 0;
    start = 1;
    for (int i = 0; i < 50 && !elem_valid; i++) begin
      @(posedge clk);
      #1;
      start = 0;
    end
    chk("rst_in_issue", elem_valid, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst_abort", all_outs(), 0);
    rst = 0;
    @(posedge clk);
    #1;
    chk("rst_no_done", {busy, done}, 0);
    run(1, 0);
    // random CSR matrices
    for (int it = 0; it < 8; it++) begin
      int m;
      rp[0] = 0;
      for (int r = 1; r <= NR; r++) rp[r] = rp[r - 1] + int'($urandom_range(0, 4));
      for (int j = 0; j < 64; j++) ci[j] = int'($urandom & 16'hffff);
      m = int'($urandom_range(0, 2));
      run(m, m == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spmv_row_scheduler.md
# spmv_row_scheduler

CSR row scheduler for the SpMV engine. On start, walks the row-pointer array in the index SRAM (SRAM1) one row at a time and fetches each column index. It issues one nonzero element per handshake to the MAC core, then signals end-of-row so the core can commit that row's accumulator. It replaces ad-hoc read sequencing with a single FSM that owns the SRAM1 read port.

## Interface
- N_ROWS, default 16: matrix rows; row_ptr holds N_ROWS+1 entries.
- PTR_W, default 8: nonzero index width (max 2^PTR_W − 1 nonzeros).
- ADDR_W, default 10: SRAM1 address width.
- RP_BASE, default 0: SRAM1 word address of row_ptr[0].
- CI_BASE, default 64: SRAM1 word address of col_idx[0].
- Ports:
  - i_clk, in, 1: clock.
  - i_rst, in, 1: synchronous active-high reset.
  - i_start, in, 1: start pulse; sampled only in IDLE.
  - o_busy, out, 1: high in every state except IDLE.
  - o_done, out, 1: one-cycle pulse at end of run.
  - o_err, out, 1: sticky malformed-CSR flag; cleared by i_start or i_rst.
  - o_rd_en, out, 1: SRAM1 read strobe.
  - o_rd_addr, out, ADDR_W: SRAM1 read address.
  - i_rd_data, in, 16: SRAM1 data; valid exactly 1 cycle after o_rd_en.
  - o_elem_valid, out, 1: element offer to the core.
  - i_elem_ready, in, 1: core accepts the element.
  - o_elem_idx, out, PTR_W: nonzero index; the core uses it to address the value array in SRAM0.
  - o_elem_col, out, 16: column index for the input-vector lookup.
  - o_elem_last, out, 1: last nonzero of the current row.
  - o_row_valid, out, 1: end-of-row offer.
  - i_row_ready, in, 1: core has committed the row.
  - o_row_idx, out, log2(N_ROWS): current row number.
  - o_row_empty, out, 1: the row has zero nonzeros; the core writes 0.

## Operation
- Registers:
  - r: row counter.
  - ptr: current nonzero index.
  - end_ptr: row_ptr[r+1].
  - col: latched column index.
- Pointers take i_rd_data[PTR_W-1:0]. Upper bits must be zero; otherwise set o_err and go to DONE.
- FSM transitions:
  - IDLE: on i_start → RD_RP0; clear o_err and r.
  - RD_RP0: o_rd_en=1, o_rd_addr=RP_BASE → WT_RP0.
  - WT_RP0: ptr←data → RD_RP.
  - RD_RP: o_rd_en=1, o_rd_addr=RP_BASE+r+1 → WT_RP.
  - WT_RP: end_ptr←data.
    - If data < ptr: o_err=1 → DONE.
    - If data == ptr → ROW_END with o_row_empty=1.
    - Otherwise → RD_CI.
  - RD_CI: o_rd_en=1, o_rd_addr=CI_BASE+ptr → WT_CI.
  - WT_CI: col←i_rd_data → ISSUE.
  - ISSUE: o_elem_valid=1, o_elem_idx=ptr, o_elem_col=col, o_elem_last=(ptr+1==end_ptr).
    - Hold until i_elem_ready, then ptr←ptr+1.
    - If last → ROW_END, else → RD_CI.
  - ROW_END: o_row_valid=1, o_row_idx=r.
    - Hold until i_row_ready.
    - Then if r==N_ROWS−1 → DONE, else r←r+1 → RD_RP.
    - ptr carries over, because row_ptr[r+1] is the next row's start.
  - DONE: o_done=1 for one cycle → IDLE.
- Handshake rules:
  - While valid is high, valid and payload hold stable until ready.
  - Ready while valid is low is ignored.
  - Valid never depends combinationally on ready.
- i_start outside IDLE is ignored.
- An i_rd_data change in any state other than WT_* is ignored.
- o_elem_valid and o_row_valid are never high together.
- Pointer arithmetic wraps modulo 2^PTR_W. A row containing 2^PTR_W nonzeros is unsupported and is flagged by the upper-bits check on the data.

## Timing
- Reset value 0 on all outputs: o_busy, o_done, o_err, o_rd_en, o_rd_addr, o_elem_*, o_row_*. State → IDLE.
- i_rst mid-run aborts immediately. The next cycle is IDLE with all outputs 0, and no o_done is produced.
- Cycle counts (cycle 0 = IDLE with i_start=1):
  - Cycle 1: RD_RP0.
  - Cycle 4: WT_RP of row 0.
  - First o_elem_valid at cycle 7.
  - Each further nonzero takes 3 cycles with i_elem_ready held high.
  - An empty row takes 3 cycles: RD_RP, WT_RP, ROW_END.
- o_busy rises in cycle 1 and falls the cycle after DONE.
- o_done is high in the DONE cycle only.

## Test plan
1. Single row, N_ROWS=1, row_ptr={0,2}, col_idx={5,9}, ready tied high.
   - Elements (0,5,last=0) at cycle 7 and (1,9,last=1) at cycle 10.
   - o_row_valid row 0 at cycle 11.
   - o_done at cycle 12.
2. Empty rows, N_ROWS=3, row_ptr={0,0,3,3}.
   - Rows 0 and 2 are offered with o_row_empty=1.
   - Row 1 issues indices 0,1,2.
   - Exactly 3 row handshakes, then o_done.
3. Backpressure: hold i_elem_ready low for 5 cycles on the first element.
   - Valid and payload stay stable.
   - ptr does not advance.
   - Stall i_row_ready likewise; o_row_idx stays stable.
4. Malformed CSR: row_ptr={0,4,2}.
   - Row 0 completes.
   - At row 1's WT_RP: o_err=1 → DONE, and o_done pulses.
   - No element from row 1 is issued.
   - o_err holds until the next i_start.
5. Reset and start collisions:
   - Assert i_rst during ISSUE: all outputs 0 next cycle, state IDLE.
   - A restart runs fully.
   - i_start pulsed mid-run is ignored and the element sequence is unchanged.
